// File: rtl/row_fetch.sv
`default_nettype none
// ============================================================================
// Module      : row_fetch
// Description : Prefetches one display row from a 1-cycle framebuffer RAM,
//               one pixel per clock, into a shadow buffer, then commits the
//               whole packed row word to row_out in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module row_fetch #(
  parameter int COLOR_BITS    = 4,
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  parameter int COLOR_COUNT   = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ROW_ADDR_BITS-1:0]               next_row,
  output logic                                   mem_rd,
  output logic [ROW_ADDR_BITS+COL_ADDR_BITS-1:0] mem_addr,
  input  logic [COLOR_BITS*COLOR_COUNT-1:0]      mem_data,
  output logic [(2**COL_ADDR_BITS)*COLOR_BITS*COLOR_COUNT-1:0] row_out,
  output logic                                   row_valid,
  output logic                                   busy
);

  localparam int NUM_COL       = 2**COL_ADDR_BITS;
  localparam int PIX_W         = COLOR_BITS*COLOR_COUNT;
  localparam int ROW_DAT_WIDTH = NUM_COL*PIX_W;
  localparam logic [COL_ADDR_BITS-1:0] COL_LAST = '1;
  localparam logic [COL_ADDR_BITS-1:0] COL_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                     state;
  logic [ROW_ADDR_BITS-1:0]   fetch_row;
  logic [ROW_ADDR_BITS-1:0]   loaded_row;
  logic [COL_ADDR_BITS-1:0]   col;       // column currently on mem_addr
  logic [COL_ADDR_BITS-1:0]   col_next;
  logic                       cap_en;    // mem_rd delayed: mem_data valid now
  logic [COL_ADDR_BITS-1:0]   cap_col;   // col delayed: where mem_data belongs
  logic [PIX_W-1:0]           shadow [NUM_COL];
  logic [ROW_DAT_WIDTH-1:0]   shadow_flat;
  logic                       start_fetch;

  assign col_next = col + 1'b1;

  // A fetch (re)starts when IDLE sees a stale/missing row, or when the row
  // being fetched is no longer the one requested (abandon and restart).
  always_comb begin
    start_fetch = 1'b0;
    case (state)
      IDLE:         start_fetch = !row_valid || (next_row != loaded_row);
      FETCH, DRAIN: start_fetch = (next_row != fetch_row);
      default:      start_fetch = 1'b0;
    endcase
  end

  // Control FSM with registered outputs; row_out only changes on COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_row  <= '0;
      loaded_row <= '0;
      col        <= '0;
      cap_en     <= 1'b0;
      cap_col    <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      row_out    <= '0;
      row_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cap_en  <= mem_rd;
      cap_col <= col;
      if (start_fetch) begin
        state     <= FETCH;
        fetch_row <= next_row;
        col       <= '0;
        mem_rd    <= 1'b1;
        mem_addr  <= {next_row, COL_ZERO};
        busy      <= 1'b1;
      end else begin
        case (state)
          FETCH: begin
            if (col == COL_LAST) begin
              // Last column already issued; mem_addr holds its value.
              mem_rd <= 1'b0;
              state  <= DRAIN;
            end else begin
              col      <= col_next;
              mem_addr <= {fetch_row, col_next};
            end
          end
          DRAIN: begin
            state <= COMMIT;
          end
          COMMIT: begin
            row_out    <= shadow_flat;
            loaded_row <= fetch_row;
            row_valid  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Shadow buffer capture; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      shadow[cap_col] <= mem_data;
    end
  end

  // Pack pixel j into bits [j*PIX_W +: PIX_W] of the row word.
  always_comb begin
    shadow_flat = '0;
    for (int j = 0; j < NUM_COL; j++) begin
      shadow_flat[j*PIX_W +: PIX_W] = shadow[j];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_row_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_fetch
// Description : Self-checking bench for row_fetch with a behavioural RAM and
//               a latency-based reference model of the row prefetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_fetch;

  localparam int RW = 768;

  logic          clk;
  logic          rst_n;
  logic [3:0]    next_row;
  logic          mem_rd;
  logic [9:0]    mem_addr;
  logic [11:0]   mem_data;
  logic [RW-1:0] row_out;
  logic          row_valid;
  logic          busy;

  int n_checks;
  int n_fail;

  row_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_row  (next_row),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .row_out   (row_out),
    .row_valid (row_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix(input logic [3:0] r, input logic [5:0] c);
    return {r, c[3:0], r ^ c[3:0]};
  endfunction

  function automatic logic [RW-1:0] row_word(input logic [3:0] r);
    logic [RW-1:0] w;
    w = '0;
    for (int j = 0; j < 64; j++) w[j*12 +: 12] = pix(r, 6'(j));
    return w;
  endfunction

  // 1-cycle framebuffer RAM
  initial mem_data = '0;
  always @(posedge clk) begin
    if (mem_rd) mem_data <= pix(mem_addr[9:6], mem_addr[5:0]);
  end

  // Reference model: a fetch is "k cycles in"; reads occupy k=1..64,
  // k=65 drains, k=66 commits. Any request change in k=1..65 restarts at k=1.
  int            mk;
  logic [3:0]    mrow;
  logic [3:0]    mloaded;
  logic          mvalid;
  logic [RW-1:0] mrow_out;
  logic [9:0]    maddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0; mrow = '0; mloaded = '0; mvalid = 1'b0; mrow_out = '0; maddr = '0;
    end else begin
      if (mk == 0) begin
        if (!mvalid || next_row != mloaded) begin mrow = next_row; mk = 1; end
      end else if (mk <= 65) begin
        if (next_row != mrow) begin mrow = next_row; mk = 1; end
        else mk = mk + 1;
      end else begin
        mrow_out = row_word(mrow); mvalid = 1'b1; mloaded = mrow; mk = 0;
      end
      if (mk >= 1 && mk <= 64) maddr = {mrow, 6'(mk - 1)};
    end
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare all outputs to the model.
  task automatic step();
    @(negedge clk);
    check("mem_rd",    RW'(mem_rd),    RW'(mk >= 1 && mk <= 64));
    check("mem_addr",  RW'(mem_addr),  RW'(maddr));
    check("busy",      RW'(busy),      RW'(mk != 0));
    check("row_valid", RW'(row_valid), RW'(mvalid));
    check("row_out",   row_out,        mrow_out);
  endtask

  task automatic wait_col(input logic [5:0] c);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mem_rd && mem_addr[5:0] == c) found = 1'b1;
      else step();
    end
    check("wait_col_timeout", RW'(found), RW'(1));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    step();
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy) done = 1'b1;
      else step();
    end
    check("wait_idle_timeout", RW'(done), RW'(1));
  endtask

  initial begin
    int cnt_rd, f, v, n;
    logic [9:0] first_a, last_a;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    next_row = 4'd1;
    repeat (3) step();
    check("reset_row_out", row_out, '0);
    check("reset_mem_addr", RW'(mem_addr), RW'(0));

    // Initial fetch of row 1
    rst_n = 1'b1;
    cnt_rd = 0; f = -1; v = -1; first_a = '0; last_a = '0;
    for (int i = 0; i < 75; i++) begin
      step();
      if (mem_rd) begin
        if (f < 0) begin f = i; first_a = mem_addr; end
        last_a = mem_addr;
        cnt_rd++;
      end
      if (row_valid && v < 0) v = i;
    end
    check("rd_cycles", RW'(cnt_rd), RW'(64));
    check("first_addr", RW'(first_a), RW'(10'h040));
    check("last_addr", RW'(last_a), RW'(10'h07F));
    check("valid_cycle", RW'(v - f + 1), RW'(67));
    check("pixel5", RW'(row_out[71:60]), RW'(12'h154));
    check("pixel63", RW'(row_out[767:756]), RW'(12'h1FE));
    check("busy_low", RW'(busy), RW'(0));

    // Abandon a fetch of row 3 at col 20 in favour of row 2
    next_row = 4'd3;
    step();
    wait_col(6'd20);
    next_row = 4'd2;
    step();
    check("jump_addr", RW'(mem_addr), RW'(10'h080));
    check("keep_row1", row_out, row_word(4'd1));
    n = 0;
    while (row_out != row_word(4'd2) && n < 100) begin step(); n++; end
    check("row2_commit_delay", RW'(n), RW'(66));
    wait_idle();

    // Row wrap 15 -> 0
    next_row = 4'd15;
    wait_idle();
    check("row15", row_out, row_word(4'd15));
    next_row = 4'd0;
    wait_idle();
    check("row0", row_out, row_word(4'd0));

    // Reset in the middle of a fetch
    next_row = 4'd5;
    step();
    wait_col(6'd30);
    rst_n = 1'b0;
    #1;
    check("rst_row_out", row_out, '0);
    check("rst_row_valid", RW'(row_valid), RW'(0));
    check("rst_mem_rd", RW'(mem_rd), RW'(0));
    check("rst_busy", RW'(busy), RW'(0));
    step();
    rst_n = 1'b1;
    step();
    check("refetch_addr", RW'(mem_addr), RW'(10'h140));
    wait_idle();
    check("row5", row_out, row_word(4'd5));

    // Hold the request steady: no further reads
    cnt_rd = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (mem_rd) cnt_rd++;
    end
    check("hold_no_rd", RW'(cnt_rd), RW'(0));
    check("hold_row5", row_out, row_word(4'd5));

    // Random request changes at arbitrary points
    for (int it = 0; it < 30; it++) begin
      next_row = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 80)) step();
    end
    wait_idle();
    check("final_row", row_out, row_word(next_row));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
